ats_cmd_arbiter: RTL and testbench

ATS_CMD_ARBITER -- requirements
Module: ats_cmd_arbiter

---
 rtl/ats21_pkg.sv | 49 ++++
 rtl/ats_client_fsm.sv | 97 +++++++++
 rtl/ats_cmd_arbiter.sv | 109 ++++++++++
 tb/tb_ats_cmd_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - shared opcodes, field positions and mode register layout for the ATS command arbiter
package ats21_pkg;

  localparam int DEF_NUM_CLOCKS = 16;
  localparam int DEF_NUM_ALARMS = 24;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_CLK_SET = 3'b001,
    OP_CLK_ADJ = 3'b010,
    OP_MODE    = 3'b011,
    OP_RSVD    = 3'b100,
    OP_ALM_SET = 3'b101,
    OP_ALM_CLR = 3'b110,
    OP_ALM_ARM = 3'b111
  } opcode_e;

  // Field positions inside the assembled 32-bit instruction.
  localparam int OP_MSB        = 31;
  localparam int OP_LSB        = 29;
  localparam int ACTIVE_BIT    = 28;
  localparam int ALLOW_CLK_BIT = 27;
  localparam int ALLOW_ALM_BIT = 25;
  localparam int CLK_IDX_MSB   = 28;
  localparam int CLK_IDX_LSB   = 25;
  localparam int ALM_IDX_MSB   = 28;
  localparam int ALM_IDX_LSB   = 24;

  typedef struct packed {
    logic active;
    logic allow_clk_a;
    logic allow_clk_b;
    logic allow_alm_a;
    logic allow_alm_b;
  } mode_t;

  localparam mode_t MODE_RESET = mode_t'(5'b11111);

  // Resource key from the top instruction byte: clock ops and alarm ops live in
  // separate halves of the key space so a clock never collides with an alarm.
  function automatic logic [5:0] res_key(input logic [7:0] top_byte);
    logic [2:0] op;
    op = top_byte[7:5];
    if (op == OP_CLK_SET || op == OP_CLK_ADJ)
      return {2'b00, top_byte[4:1]};
    return {1'b1, top_byte[4:0]};
  endfunction

endpackage

// File: rtl/ats_client_fsm.sv
// rtl/ats_client_fsm.sv - per-client two-beat instruction assembler and validator
module ats_client_fsm
  import ats21_pkg::*;
#(
  parameter int NUM_CLOCKS = DEF_NUM_CLOCKS,
  parameter int NUM_ALARMS = DEF_NUM_ALARMS
) (
  input  logic        clk_1x,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrl,
  input  logic        active,
  input  logic        allow_clk,
  input  logic        allow_alm,
  input  logic        fin_ack,
  input  logic        fin_nack,
  output logic        busy,
  output logic        ack,
  output logic        nack,
  output logic        pend,
  output logic        ok,
  output logic        is_mode,
  output logic [5:0]  key,
  output logic [31:0] instr
);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_PEND} state_e;

  state_e     state;
  logic [2:0] op;
  logic [3:0] clk_idx;
  logic [4:0] alm_idx;
  logic       is_clk;
  logic       is_alm;
  logic       clk_in_range;
  logic       alm_in_range;

  assign busy = (state != ST_IDLE);
  assign pend = (state == ST_PEND);
  assign key  = res_key(instr[31:24]);

  // Decode the held instruction; only meaningful while pending.
  always_comb begin
    op           = instr[OP_MSB:OP_LSB];
    clk_idx      = instr[CLK_IDX_MSB:CLK_IDX_LSB];
    alm_idx      = instr[ALM_IDX_MSB:ALM_IDX_LSB];
    is_clk       = (op == OP_CLK_SET) || (op == OP_CLK_ADJ);
    is_alm       = (op == OP_ALM_SET) || (op == OP_ALM_CLR) || (op == OP_ALM_ARM);
    is_mode      = (op == OP_MODE);
    clk_in_range = ({28'd0, clk_idx} < 32'(NUM_CLOCKS));
    alm_in_range = ({27'd0, alm_idx} < 32'(NUM_ALARMS));
    ok           = is_mode ||
                   (active && ((is_clk && allow_clk && clk_in_range) ||
                               (is_alm && allow_alm && alm_in_range)));
  end

  // Assembler FSM: upper beat, lower beat, then wait for the arbiter's verdict.
  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      instr <= '0;
      ack   <= 1'b0;
      nack  <= 1'b0;
    end else begin
      ack  <= 1'b0;
      nack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && (ctrl[15:13] != OP_NOP)) begin
            instr[31:16] <= ctrl;
            state        <= ST_HI;
          end
        end
        ST_HI: begin
          if (req) begin
            instr[15:0] <= ctrl;
            state       <= ST_PEND;
          end else begin
            nack  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_PEND: begin
          if (fin_ack) begin
            ack   <= 1'b1;
            state <= ST_IDLE;
          end else if (fin_nack) begin
            nack  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ats_cmd_arbiter.sv
// rtl/ats_cmd_arbiter.sv - two-client instruction arbiter onto a single downstream command port
module ats_cmd_arbiter
  import ats21_pkg::*;
#(
  parameter int NUM_CLOCKS = DEF_NUM_CLOCKS,
  parameter int NUM_ALARMS = DEF_NUM_ALARMS
) (
  input  logic        clk_1x,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] ctrl_a,
  input  logic [15:0] ctrl_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        nack_a,
  output logic        nack_b,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_src,
  output logic [4:0]  mode
);

  mode_t       mode_q;
  logic        rr;
  logic        lock_v;
  logic        lock_src;
  logic        pend_a, pend_b, ok_a, ok_b, is_mode_a, is_mode_b;
  logic [5:0]  key_a, key_b;
  logic [31:0] instr_a, instr_b;
  logic        val_a, val_b, fwd_a, fwd_b, md_a, md_b, fail_a, fail_b;
  logic        sel, clash, hs;
  logic        fin_ack_a, fin_ack_b, fin_nack_a, fin_nack_b;

  assign mode = mode_q;

  ats_client_fsm #(.NUM_CLOCKS(NUM_CLOCKS), .NUM_ALARMS(NUM_ALARMS)) u_client_a (
    .clk_1x(clk_1x), .reset(reset), .req(req_a), .ctrl(ctrl_a),
    .active(mode_q.active), .allow_clk(mode_q.allow_clk_a), .allow_alm(mode_q.allow_alm_a),
    .fin_ack(fin_ack_a), .fin_nack(fin_nack_a),
    .busy(busy_a), .ack(ack_a), .nack(nack_a), .pend(pend_a), .ok(ok_a),
    .is_mode(is_mode_a), .key(key_a), .instr(instr_a)
  );

  ats_client_fsm #(.NUM_CLOCKS(NUM_CLOCKS), .NUM_ALARMS(NUM_ALARMS)) u_client_b (
    .clk_1x(clk_1x), .reset(reset), .req(req_b), .ctrl(ctrl_b),
    .active(mode_q.active), .allow_clk(mode_q.allow_clk_b), .allow_alm(mode_q.allow_alm_b),
    .fin_ack(fin_ack_b), .fin_nack(fin_nack_b),
    .busy(busy_b), .ack(ack_b), .nack(nack_b), .pend(pend_b), .ok(ok_b),
    .is_mode(is_mode_b), .key(key_b), .instr(instr_b)
  );

  // Arbitration and verdicts; a command already on the port stays valid and
  // selected until it handshakes, even if the mode register changes under it.
  always_comb begin
    val_a      = pend_a && (ok_a || (lock_v && !lock_src));
    val_b      = pend_b && (ok_b || (lock_v && lock_src));
    fwd_a      = val_a && !is_mode_a;
    fwd_b      = val_b && !is_mode_b;
    md_a       = val_a && is_mode_a;
    md_b       = val_b && is_mode_b;
    fail_a     = pend_a && !val_a;
    fail_b     = pend_b && !val_b;
    if (lock_v)
      sel = lock_src;
    else if (fwd_a && fwd_b)
      sel = rr;
    else
      sel = !fwd_a;
    cmd_valid  = fwd_a || fwd_b;
    clash      = fwd_a && fwd_b && (key_a == key_b);
    hs         = cmd_valid && cmd_ready;
    fin_ack_a  = (hs && !sel) || (md_a && !md_b);
    fin_ack_b  = (hs && sel) || (md_b && !md_a);
    fin_nack_a = fail_a || (md_a && md_b) || (clash && sel);
    fin_nack_b = fail_b || (md_a && md_b) || (clash && !sel);
    cmd_src    = cmd_valid && sel;
    cmd_data   = !cmd_valid ? 32'd0 : (sel ? instr_b : instr_a);
  end

  // Round-robin pointer, presentation lock and mode register. Client A owns the
  // global active bit; client B may only change its own allow bits.
  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      rr       <= 1'b0;
      lock_v   <= 1'b0;
      lock_src <= 1'b0;
      mode_q   <= MODE_RESET;
    end else begin
      if (hs)
        rr <= !sel;
      lock_v   <= cmd_valid && !cmd_ready;
      lock_src <= sel;
      if (md_a && !md_b) begin
        mode_q.active      <= instr_a[ACTIVE_BIT];
        mode_q.allow_clk_a <= instr_a[ALLOW_CLK_BIT];
        mode_q.allow_alm_a <= instr_a[ALLOW_ALM_BIT];
      end
      if (md_b && !md_a) begin
        mode_q.allow_clk_b <= instr_b[ALLOW_CLK_BIT];
        mode_q.allow_alm_b <= instr_b[ALLOW_ALM_BIT];
      end
    end
  end

endmodule

// File: tb/tb_ats_cmd_arbiter.sv
// tb/tb_ats_cmd_arbiter.sv - directed self-checking bench for ats_cmd_arbiter
module tb_ats_cmd_arbiter;

  logic        clk_1x;
  logic        reset;
  logic        req_a, req_b;
  logic [15:0] ctrl_a, ctrl_b;
  logic        busy_a, busy_b, ack_a, ack_b, nack_a, nack_b;
  logic        cmd_valid, cmd_ready, cmd_src;
  logic [31:0] cmd_data;
  logic [4:0]  mode;

  int checks = 0;
  int errors = 0;

  ats_cmd_arbiter dut (
    .clk_1x(clk_1x), .reset(reset),
    .req_a(req_a), .req_b(req_b), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
    .busy_a(busy_a), .busy_b(busy_b), .ack_a(ack_a), .ack_b(ack_b),
    .nack_a(nack_a), .nack_b(nack_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_src(cmd_src), .mode(mode)
  );

  initial clk_1x = 1'b0;
  always #5 clk_1x = ~clk_1x;

  task automatic tick();
    @(posedge clk_1x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives beat0 then beat1 on the enabled clients; returns in cycle N+2.
  task automatic send(input logic ea, input logic [15:0] a0, input logic [15:0] a1,
                      input logic eb, input logic [15:0] b0, input logic [15:0] b1);
    req_a = ea; ctrl_a = a0; req_b = eb; ctrl_b = b0;
    tick();
    ctrl_a = a1; ctrl_b = b1;
    tick();
    req_a = 1'b0; req_b = 1'b0; ctrl_a = 16'h0; ctrl_b = 16'h0;
  endtask

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; ctrl_a = 16'h0; ctrl_b = 16'h0; cmd_ready = 1'b1;
    tick(); tick();
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_cmd_src", cmd_src, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_nack_a", nack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_nack_b", nack_b, 0);
    chk("rst_mode", mode, 5'b11111);
    reset = 1'b0;
    tick();

    // nop beat is ignored
    req_a = 1'b1; ctrl_a = 16'h0000;
    tick();
    req_a = 1'b0;
    chk("nop_busy_a", busy_a, 0);
    tick();
    chk("nop_nack_a", nack_a, 0);
    chk("nop_ack_a", ack_a, 0);

    // missing second beat aborts with nack
    req_a = 1'b1; ctrl_a = 16'h2440;
    tick();
    chk("abort_busy_hi", busy_a, 1);
    req_a = 1'b0;
    tick();
    chk("abort_nack_a", nack_a, 1);
    chk("abort_busy_a", busy_a, 0);
    chk("abort_cmd_valid", cmd_valid, 0);
    tick();
    chk("abort_nack_clr", nack_a, 0);

    // same alarm from both clients: A wins, then B wins on the repeat
    send(1'b1, 16'hA000, 16'h0005, 1'b1, 16'hA020, 16'h0007);
    chk("rr1_valid", cmd_valid, 1);
    chk("rr1_src", cmd_src, 0);
    chk("rr1_data", cmd_data, 32'hA0000005);
    tick();
    chk("rr1_ack_a", ack_a, 1);
    chk("rr1_nack_b", nack_b, 1);
    chk("rr1_nack_a", nack_a, 0);
    chk("rr1_ack_b", ack_b, 0);
    chk("rr1_busy_b", busy_b, 0);
    tick();
    send(1'b1, 16'hA000, 16'h0005, 1'b1, 16'hA020, 16'h0007);
    chk("rr2_src", cmd_src, 1);
    chk("rr2_data", cmd_data, 32'hA0200007);
    tick();
    chk("rr2_ack_b", ack_b, 1);
    chk("rr2_nack_a", nack_a, 1);
    chk("rr2_ack_a", ack_a, 0);
    tick();

    // B clears its allow bits
    send(1'b0, 16'h0, 16'h0, 1'b1, 16'h6000, 16'h0000);
    chk("modeb_no_fwd", cmd_valid, 0);
    tick();
    chk("modeb_ack_b", ack_b, 1);
    chk("modeb_mode", mode, 5'b11010);
    tick();
    send(1'b0, 16'h0, 16'h0, 1'b1, 16'h2440, 16'h0010);
    chk("b_denied_valid", cmd_valid, 0);
    tick();
    chk("b_denied_nack", nack_b, 1);
    chk("b_denied_ack", ack_b, 0);
    tick();

    // A set clock 2: latency N..N+3, then back-to-back from the ack cycle
    send(1'b1, 16'h2440, 16'h0010, 1'b0, 16'h0, 16'h0);
    chk("a_set_valid", cmd_valid, 1);
    chk("a_set_data", cmd_data, 32'h24400010);
    chk("a_set_src", cmd_src, 0);
    chk("a_set_early_ack", ack_a, 0);
    tick();
    chk("a_set_ack", ack_a, 1);
    chk("a_set_nack", nack_a, 0);
    chk("a_set_busy", busy_a, 0);
    req_a = 1'b1; ctrl_a = 16'h2600;
    tick();
    ctrl_a = 16'h0022;
    tick();
    req_a = 1'b0; ctrl_a = 16'h0;
    chk("b2b_data", cmd_data, 32'h26000022);
    tick();
    chk("b2b_ack", ack_a, 1);
    tick();

    // alarm 24 is out of range
    send(1'b1, 16'hB800, 16'h0000, 1'b0, 16'h0, 16'h0);
    chk("alm24_valid", cmd_valid, 0);
    tick();
    chk("alm24_nack", nack_a, 1);
    chk("alm24_ack", ack_a, 0);
    tick();

    // B restores its allow bits
    send(1'b0, 16'h0, 16'h0, 1'b1, 16'h7A00, 16'h0000);
    tick();
    chk("restore_ack_b", ack_b, 1);
    chk("restore_mode", mode, 5'b11111);
    tick();

    // backpressure: A held 5 cycles while B queues behind it
    cmd_ready = 1'b0;
    send(1'b1, 16'h4640, 16'h1234, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_data", cmd_data, 32'h46401234);
      chk("hold_src", cmd_src, 0);
      chk("hold_ack", ack_a, 0);
      if (i == 0) begin req_b = 1'b1; ctrl_b = 16'hA000; end
      if (i == 1) ctrl_b = 16'h0001;
      if (i == 2) begin req_b = 1'b0; ctrl_b = 16'h0; end
      tick();
    end
    cmd_ready = 1'b1;
    chk("hold_last_src", cmd_src, 0);
    tick();
    chk("hold_ack_a", ack_a, 1);
    chk("queued_valid", cmd_valid, 1);
    chk("queued_src", cmd_src, 1);
    chk("queued_data", cmd_data, 32'hA0000001);
    tick();
    chk("queued_ack_b", ack_b, 1);
    chk("queued_idle", cmd_valid, 0);
    tick();

    // both clients issue mode together: both refused, mode untouched
    send(1'b1, 16'h7000, 16'h0000, 1'b1, 16'h6000, 16'h0000);
    tick();
    chk("mm_nack_a", nack_a, 1);
    chk("mm_nack_b", nack_b, 1);
    chk("mm_ack_a", ack_a, 0);
    chk("mm_mode", mode, 5'b11111);
    tick();

    // reset in the middle of an instruction
    send(1'b1, 16'h7000, 16'h0000, 1'b0, 16'h0, 16'h0);
    tick();
    chk("modea_ack", ack_a, 1);
    chk("modea_mode", mode, 5'b10101);
    tick();
    req_a = 1'b1; ctrl_a = 16'h2440;
    tick();
    chk("mid_busy_hi", busy_a, 1);
    req_a = 1'b0; ctrl_a = 16'h0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_mode", mode, 5'b11111);
    chk("mid_rst_nack", nack_a, 0);
    chk("mid_rst_ack", ack_a, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_nack", nack_a, 0);
    chk("post_rst_busy", busy_a, 0);
    tick();
    chk("post_rst_nack2", nack_a, 0);
    chk("post_rst_ack2", ack_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
